// File: rtl/post_normalize_round.sv
// post_normalize_round: iterative FP32 normalize, round-to-nearest-even and pack with valid/ready
module post_normalize_round #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic [EXP_W-1:0]        in_exp,
  input  logic [MANT_W+1:0]       in_mant,
  input  logic [2:0]              in_grs,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   result,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    inexact
);
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
  state_t state;
  logic [24:0] m;
  logic [8:0] e;
  logic g, r, st, sg, sub, byp;
  logic inc, ovf, inx;
  logic [24:0] m24;
  logic [8:0] ef;
  assign in_ready = (state == IDLE);
  always_comb begin
    inc = g & (r | st | m[0]);
    m24 = {1'b0, m[23:0]} + {24'b0, inc};
    ef  = sub ? {8'b0, m24[23]} : e + {8'b0, m24[24]};
    ovf = ef >= 9'd255;
    inx = g | r | st;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
      m         <= '0;
      e         <= '0;
      {g, r, st, sg, sub, byp} <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          m         <= in_mant;
          e         <= {1'b0, in_exp};
          {g, r, st} <= in_grs;
          sg        <= in_sign;
          sub       <= 1'b0;
          byp       <= 1'b0;
          state     <= NORM;
        end
        NORM: if (e == 9'd255) begin
          result <= {sg, 8'hFF, 23'h0};
          byp    <= 1'b1;
          state  <= ROUND;
        end else if (m == 25'd0 && !inx) begin
          result <= '0;
          byp    <= 1'b1;
          state  <= ROUND;
        end else if (m[24]) begin
          m     <= {1'b0, m[24:1]};
          g     <= m[0];
          r     <= g;
          st    <= r | st;
          e     <= e + 9'd1;
          state <= ROUND;
        end else if (!m[23] && e > 9'd1) begin
          m <= {m[23:0], g};
          g <= r;
          r <= 1'b0;
          e <= e - 9'd1;
        end else begin
          sub   <= !m[23];
          state <= ROUND;
        end
        ROUND: begin
          if (!byp) begin
            result    <= ovf ? {sg, 8'hFF, 23'h0} : {sg, ef[7:0], m24[22:0]};
            overflow  <= ovf;
            inexact   <= inx;
            underflow <= (ef == 9'd0) & inx;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          overflow  <= 1'b0;
          underflow <= 1'b0;
          inexact   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_post_normalize_round.sv
// tb_post_normalize_round: scoreboard bench for the FP32 post-normalize/round stage
module tb_post_normalize_round;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_sign = 0, out_valid, out_ready = 1;
  logic [7:0] in_exp = 0;
  logic [24:0] in_mant = 0;
  logic [2:0] in_grs = 0;
  logic [31:0] result;
  logic overflow, underflow, inexact;
  int checks = 0, failures = 0;
  typedef struct {logic [31:0] res; logic ov, uf, ix; int lat;} exp_t;
  exp_t q[$];
  post_normalize_round dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_grs(in_grs),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow), .inexact(inexact)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic s, input logic [7:0] e, input logic [24:0] m,
                        input logic [2:0] grs, input logic [31:0] res, input logic ov, input logic uf,
                        input logic ix, input int lat, input int hold);
    exp_t x;
    int n;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 1);
    in_sign = s; in_exp = e; in_mant = m; in_grs = grs; in_valid = 1;
    q.push_back('{res, ov, uf, ix, lat});
    @(posedge clk); #1;
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    x = q.pop_front();
    chk({tag, "_latency"}, n + 1, x.lat);
    chk({tag, "_result"}, result, x.res);
    chk({tag, "_flags"}, {29'b0, overflow, underflow, inexact}, {29'b0, x.ov, x.uf, x.ix});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_result"}, result, x.res);
      chk({tag, "_hold_valid_ready"}, {30'b0, out_valid, in_ready}, 32'b10);
    end
    out_ready = 1;
    @(posedge clk); #1;
    chk({tag, "_after_hs"}, {29'b0, out_valid, in_ready, inexact}, 32'b010);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {out_valid, overflow, underflow, inexact, result[27:0]}, 0);
    chk("reset_result", result, 0);
    rst = 0;
    #1;
    chk("reset_in_ready", {31'b0, in_ready}, 1);
    run_op("one_plus_one", 0, 127, 25'h1000000, 3'b000, 32'h40000000, 0, 0, 0, 3, 0);
    run_op("cancel",       0, 127, 25'h0000001, 3'b000, 32'h34000000, 0, 0, 0, 26, 0);
    run_op("tie_odd",      0, 127, 25'h0800001, 3'b100, 32'h3F800002, 0, 0, 1, 3, 0);
    run_op("tie_even",     0, 127, 25'h0800000, 3'b100, 32'h3F800000, 0, 0, 1, 3, 0);
    run_op("overflow",     0, 254, 25'h1FFFFFF, 3'b111, 32'h7F800000, 1, 0, 1, 3, 0);
    run_op("zero",         1, 100, 25'h0000000, 3'b000, 32'h00000000, 0, 0, 0, 3, 0);
    run_op("subnormal",    0, 1,   25'h0400000, 3'b000, 32'h00400000, 0, 0, 0, 3, 0);
    run_op("sub_uflow",    0, 1,   25'h0400000, 3'b001, 32'h00400000, 0, 1, 1, 3, 0);
    run_op("sub_to_norm",  0, 1,   25'h07FFFFF, 3'b110, 32'h00800000, 0, 0, 1, 3, 0);
    run_op("round_carry",  0, 127, 25'h0FFFFFF, 3'b110, 32'h40000000, 0, 0, 1, 3, 0);
    run_op("inf_in",       1, 255, 25'h0123456, 3'b101, 32'hFF800000, 0, 0, 0, 3, 0);
    run_op("shift_guard",  0, 127, 25'h0400000, 3'b100, 32'h3F000001, 0, 0, 0, 4, 0);
    run_op("backpressure", 1, 127, 25'h1000000, 3'b000, 32'hC0000000, 0, 0, 0, 3, 5);
    @(posedge clk); #1;
    in_exp = 127; in_mant = 25'h0000001; in_grs = 0; in_sign = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    #1;
    chk("midop_reset", {30'b0, out_valid, in_ready}, 32'b01);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("post_reset_ready", {30'b0, out_valid, in_ready}, 32'b01);
    begin
      int seen = 0;
      for (int i = 0; i < 30; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("no_valid_after_abort", seen, 0);
    end
    run_op("after_abort",  0, 127, 25'h1000000, 3'b000, 32'h40000000, 0, 0, 0, 3, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
